// File: rtl/mux_seq_pkg.sv
// Shared types for the mux_seq block:
// FSM state encoding and mode constants.
package mux_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

endpackage

// File: rtl/mux_n.sv
// Combinational N:1 channel selector.
// data_i: flattened channels, idx_i: channel index, data_o: selected channel.
module mux_n
  import mux_seq_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int NUM_IN = 2,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        idx_i,
  output logic [WIDTH-1:0]        data_o
);

  // An index past the last channel yields zero.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (idx_i == SEL_W'(i)) begin
        data_o = data_i[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_seq.sv
// Registered channel mux with manual select and auto-sequence modes.
// Ports: clk, reset_n, mux_in, mode, sel, start, hold -> mux_out,
// out_valid, cur_sel, busy, done.
module mux_seq
  import mux_seq_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int NUM_IN = 2,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] mux_in,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    start,
  input  logic                    hold,
  output logic [WIDTH-1:0]        mux_out,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    busy,
  output logic                    done
);

  localparam logic [SEL_W:0]   NUM_W = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_IN - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             armed_q;

  logic [SEL_W-1:0] mux_idx;
  logic [WIDTH-1:0] mux_sel;
  logic             sel_ok;

  // RUN walks the internal index; IDLE follows the manual select.
  assign mux_idx = (state_q == RUN) ? idx_q : sel;
  assign sel_ok  = {1'b0, sel} < NUM_W;

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .data_i (mux_in),
    .idx_i  (mux_idx),
    .data_o (mux_sel)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    out_d   = out_q;
    cur_d   = cur_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (mode == MODE_MANUAL) begin
          if (sel_ok) begin
            out_d   = mux_sel;
            cur_d   = sel;
            valid_d = 1'b1;
          end
        end else if (start && armed_q) begin
          state_d = RUN;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      (state_q == RUN): begin
        if (!hold) begin
          out_d   = mux_sel;
          cur_d   = idx_q;
          valid_d = 1'b1;
          if (idx_q == LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // armed_q masks start on the edge that releases reset, so a start
  // pulse racing the reset release can never launch a sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      out_q   <= '0;
      cur_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      armed_q <= 1'b1;
    end
  end

  assign mux_out   = out_q;
  assign out_valid = valid_q;
  assign cur_sel   = cur_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mux_seq.sv
// Self-checking bench for mux_seq (WIDTH=4, NUM_IN=3):
// directed scenarios plus randomized traffic against a queue model.
module tb_mux_seq;

  localparam int W  = 4;
  localparam int N  = 3;
  localparam int SW = $clog2(N);

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N*W-1:0]  mux_in;
  logic            mode;
  logic [SW-1:0]   sel;
  logic            start;
  logic            hold;
  logic [W-1:0]    mux_out;
  logic            out_valid;
  logic [SW-1:0]   cur_sel;
  logic            busy;
  logic            done;

  int nchk = 0;
  int nerr = 0;

  mux_seq #(
    .WIDTH  (W),
    .NUM_IN (N)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mux_in    (mux_in),
    .mode      (mode),
    .sel       (sel),
    .start     (start),
    .hold      (hold),
    .mux_out   (mux_out),
    .out_valid (out_valid),
    .cur_sel   (cur_sel),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference: a pending-channel queue per auto sequence.
  int         q[$];
  logic [3:0] m_out;
  int         m_cur;
  bit         m_valid;
  bit         m_done;
  bit         m_armed;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ch(int i);
    return mux_in[i*W +: W];
  endfunction

  task automatic model_reset();
    q.delete();
    m_out   = '0;
    m_cur   = 0;
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_armed = 1'b0;
  endtask

  task automatic model_step();
    int c;
    m_done  = 1'b0;
    m_valid = 1'b0;
    if (q.size() == 0) begin
      if (!mode) begin
        if (int'(sel) < N) begin
          m_out   = ch(int'(sel));
          m_cur   = int'(sel);
          m_valid = 1'b1;
        end
      end else if (start && m_armed) begin
        for (int i = 0; i < N; i++) q.push_back(i);
      end
    end else if (!hold) begin
      c       = q.pop_front();
      m_out   = ch(c);
      m_cur   = c;
      m_valid = 1'b1;
      m_done  = (q.size() == 0);
    end
    m_armed = 1'b1;
  endtask

  task automatic cmp_model();
    check("mdl_out",  32'(mux_out),   32'(m_out));
    check("mdl_cur",  32'(cur_sel),   m_cur);
    check("mdl_vld",  32'(out_valid), 32'(m_valid));
    check("mdl_busy", 32'(busy),      32'(q.size() != 0));
    check("mdl_done", 32'(done),      32'(m_done));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    cmp_model();
  endtask

  task automatic chk_zero(string tag);
    check({tag, "_out"},  32'(mux_out),   0);
    check({tag, "_cur"},  32'(cur_sel),   0);
    check({tag, "_vld"},  32'(out_valid), 0);
    check({tag, "_busy"}, 32'(busy),      0);
    check({tag, "_done"}, 32'(done),      0);
  endtask

  // Asynchronous reset taken away from the clock edge.
  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_zero("rst");
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [3:0] vals[3] = '{4'h3, 4'h5, 4'hA};
  int         bcnt;
  int         ph;

  initial begin
    #200000;
    $display("FAIL timeout nchk=%0d", nchk);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    mux_in  = {4'hA, 4'h7, 4'h9};
    mode    = 1'b0;
    sel     = '0;
    start   = 1'b0;
    hold    = 1'b0;
    model_reset();
    #2;
    chk_zero("init");
    @(negedge clk);
    reset_n = 1'b1;

    // Manual select toggling every 5 cycles.
    for (int t = 0; t < 4; t++) begin
      sel = SW'(t % 2);
      for (int k = 0; k < 5; k++) begin
        cyc();
        check("man_out", 32'(mux_out), (t % 2) ? 7 : 9);
        check("man_vld", 32'(out_valid), 1);
      end
    end

    // Out-of-range select holds the output.
    sel = 2'd3;
    cyc();
    check("bad_out", 32'(mux_out), 7);
    check("bad_cur", 32'(cur_sel), 1);
    check("bad_vld", 32'(out_valid), 0);

    // Plain auto sequence.
    mux_in = {4'hA, 4'h5, 4'h3};
    mode   = 1'b1;
    start  = 1'b1;
    cyc();
    check("st_busy", 32'(busy), 1);
    check("st_vld", 32'(out_valid), 0);
    bcnt  = 1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      cyc();
      check("seq_out", 32'(mux_out), 32'(vals[i]));
      check("seq_cur", 32'(cur_sel), i);
      check("seq_done", 32'(done), 32'(i == N - 1));
      if (busy) bcnt++;
    end
    check("busy_len", bcnt, N);
    cyc();
    check("done_clr", 32'(done), 0);

    // Hold for two cycles after channel 1.
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    check("h_pre", 32'(mux_out), 5);
    hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      check("h_out", 32'(mux_out), 5);
      check("h_vld", 32'(out_valid), 0);
      check("h_done", 32'(done), 0);
    end
    hold = 1'b0;
    cyc();
    check("h_last", 32'(mux_out), 10);
    check("h_done2", 32'(done), 1);

    // Reset mid-sequence, then replay from channel 0.
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    do_reset();
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check("rp_out", 32'(mux_out), 3);
    check("rp_cur", 32'(cur_sel), 0);
    cyc();
    cyc();
    check("rp_done", 32'(done), 1);

    // Start held high: back-to-back with one idle gap.
    start = 1'b1;
    for (int j = 0; j < 12; j++) begin
      cyc();
      ph = j % (N + 1);
      check("b2b_vld", 32'(out_valid), 32'(ph != 0));
      if (ph != 0) check("b2b_out", 32'(mux_out), 32'(vals[ph-1]));
      check("b2b_done", 32'(done), 32'(ph == N));
    end
    start = 1'b0;
    cyc();

    // Start coinciding with the reset-releasing edge is ignored.
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    reset_n = 1'b1;
    start   = 1'b1;
    #1;
    chk_zero("rel");
    start = 1'b0;
    cyc();
    cyc();
    check("rel_busy", 32'(busy), 0);

    // Randomized traffic.
    for (int r = 0; r < 400; r++) begin
      mux_in = (N*W)'($urandom);
      mode   = ($urandom_range(0, 3) != 0);
      sel    = SW'($urandom_range(0, 3));
      start  = ($urandom_range(0, 2) == 0);
      hold   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) do_reset();
      else cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
